// File: rtl/osc_bank.sv
// Time-multiplexed oscillator bank: N_VOICES square/pulse/saw voices mixed serially with saturation.
// Optional sawtooth mode is enabled by defining OSC_BANK_SAW_EN; otherwise mode 3 acts as off.
module osc_bank #(
    parameter int N_VOICES      = 4,
    parameter int SAMPLE_W      = 16,
    parameter int PHASE_W       = 24,
    parameter int SAMPLE_PERIOD = 2272
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2*N_VOICES-1:0]        voice_mode,
    input  logic [PHASE_W*N_VOICES-1:0]  voice_delta,
    input  logic [PHASE_W*N_VOICES-1:0]  voice_width,
    input  logic [4*N_VOICES-1:0]        voice_shift,
    input  logic [N_VOICES-1:0]          voice_sync,
    output logic [SAMPLE_W-1:0]          sample_out,
    output logic                         sample_valid,
    output logic                         busy
);

    localparam int ACC_W = SAMPLE_W + $clog2(N_VOICES) + 1;
    localparam int IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
    localparam int CNT_W = $clog2(SAMPLE_PERIOD);

    localparam logic signed [SAMPLE_W-1:0] FULL = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

    state_t                   state, state_next;
    logic [CNT_W-1:0]         cnt;
    logic [IDX_W-1:0]         idx;
    logic signed [ACC_W-1:0]  acc;
    logic [PHASE_W-1:0]       phase [N_VOICES];
    logic [N_VOICES-1:0]      sync_flag;
    logic                     tick;

    logic [1:0]               sel_mode;
    logic [PHASE_W-1:0]       sel_delta, sel_width, sel_phase;
    logic [3:0]               sel_shift;
    logic                     sel_sync;

    logic [PHASE_W-1:0]       p, next_phase;
    logic                     active;
    logic signed [SAMPLE_W-1:0] wave;
    logic signed [ACC_W-1:0]  wave_ext, contrib;
    logic [SAMPLE_W-1:0]      sat;

    assign tick = (cnt == '0);

    // Select the configuration and state of the voice visited this cycle.
    always_comb begin
        sel_mode  = '0;
        sel_delta = '0;
        sel_width = '0;
        sel_shift = '0;
        sel_phase = '0;
        sel_sync  = 1'b0;
        for (int unsigned i = 0; i < N_VOICES; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_mode  = voice_mode[2*i +: 2];
                sel_delta = voice_delta[PHASE_W*i +: PHASE_W];
                sel_width = voice_width[PHASE_W*i +: PHASE_W];
                sel_shift = voice_shift[4*i +: 4];
                sel_phase = phase[i];
                sel_sync  = sync_flag[i] | voice_sync[i];
            end
        end
    end

    always_comb begin
        p      = sel_sync ? '0 : sel_phase;
        active = 1'b0;
        wave   = '0;
        case (sel_mode)
            2'd1: begin
                active = 1'b1;
                wave   = p[PHASE_W-1] ? -FULL : FULL;
            end
            2'd2: begin
                active = 1'b1;
                wave   = (p < sel_width) ? FULL : -FULL;
            end
`ifdef OSC_BANK_SAW_EN
            2'd3: begin
                active = 1'b1;
                wave   = {~p[PHASE_W-1], p[PHASE_W-2 -: SAMPLE_W-1]};
            end
`endif
            default: ;
        endcase
        wave_ext   = ACC_W'(wave);
        contrib    = wave_ext >>> sel_shift;
        next_phase = active ? (p + sel_delta) : '0;
    end

    always_comb begin
        if (acc > ACC_MAX)
            sat = ACC_MAX[SAMPLE_W-1:0];
        else if (acc < ACC_MIN)
            sat = ACC_MIN[SAMPLE_W-1:0];
        else
            sat = acc[SAMPLE_W-1:0];
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (tick) state_next = ACCUM;
            ACCUM:   if (idx == IDX_W'(N_VOICES-1)) state_next = EMIT;
            EMIT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            acc          <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            sync_flag    <= '0;
            for (int unsigned i = 0; i < N_VOICES; i++)
                phase[i] <= '0;
        end else begin
            state        <= state_next;
            cnt          <= (cnt == CNT_W'(SAMPLE_PERIOD-1)) ? '0 : cnt + CNT_W'(1);
            sample_valid <= (state == EMIT);

            // A visit consumes the pending sync, including one arriving in that same cycle.
            for (int unsigned i = 0; i < N_VOICES; i++) begin
                if (state == ACCUM && idx == IDX_W'(i)) begin
                    phase[i]     <= next_phase;
                    sync_flag[i] <= 1'b0;
                end else if (voice_sync[i]) begin
                    sync_flag[i] <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (tick) begin
                        acc <= '0;
                        idx <= '0;
                    end
                end
                ACCUM: begin
                    acc <= acc + contrib;
                    idx <= idx + IDX_W'(1);
                end
                EMIT:    sample_out <= sat;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_osc_bank.sv
// Scoreboard bench for osc_bank: expected samples are queued as stimulus is set up and
// checked on each sample_valid strobe; frame timing and busy are checked every cycle.
module tb_osc_bank;

    localparam int N  = 4;
    localparam int SW = 16;
    localparam int PW = 24;
    localparam int P  = 2272;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [2*N-1:0]    voice_mode  = '0;
    logic [PW*N-1:0]   voice_delta = '0;
    logic [PW*N-1:0]   voice_width = '0;
    logic [4*N-1:0]    voice_shift = '0;
    logic [N-1:0]      voice_sync  = '0;
    logic [SW-1:0]     sample_out;
    logic              sample_valid;
    logic              busy;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int n_seen = 0;
    int cyc = 0;
    bit in_rst = 1'b1;

    osc_bank #(
        .N_VOICES(N),
        .SAMPLE_W(SW),
        .PHASE_W(PW),
        .SAMPLE_PERIOD(P)
    ) dut (
        .clk(clk),
        .rst(rst),
        .voice_mode(voice_mode),
        .voice_delta(voice_delta),
        .voice_width(voice_width),
        .voice_shift(voice_shift),
        .voice_sync(voice_sync),
        .sample_out(sample_out),
        .sample_valid(sample_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Cycles since reset release; cycle 0 is the first tick.
    always @(posedge clk) begin
        if (rst) begin
            cyc    <= 0;
            in_rst <= 1'b1;
        end else begin
            cyc    <= cyc + 1;
            in_rst <= 1'b0;
        end
    end

    always @(negedge clk) begin
        int ph;
        ph = cyc % P;
        if (in_rst) begin
            check_eq("rst_out", int'(sample_out), 0);
            check_eq("rst_valid", int'(sample_valid), 0);
            check_eq("rst_busy", int'(busy), 0);
        end else begin
            check_eq("busy", int'(busy), int'(ph >= 1 && ph <= N + 1));
            check_eq("valid", int'(sample_valid), int'(ph == N + 2));
        end
        if (sample_valid) begin
            n_seen++;
            if (exp_q.size() == 0)
                check_eq("spurious_valid", int'(sample_valid), 0);
            else
                check_eq("sample", int'($signed(sample_out)), exp_q.pop_front());
        end
    end

    task automatic set_voice(input int v, input logic [1:0] m, input logic [PW-1:0] d,
                             input logic [PW-1:0] w, input logic [3:0] s);
        voice_mode[2*v +: 2]    = m;
        voice_delta[PW*v +: PW] = d;
        voice_width[PW*v +: PW] = w;
        voice_shift[4*v +: 4]   = s;
    endtask

    task automatic all_off();
        for (int v = 0; v < N; v++) set_voice(v, 2'd0, '0, '0, 4'd0);
    endtask

    task automatic wait_samples(input int n);
        int target;
        int budget;
        target = n_seen + n;
        budget = n * P + 20;
        while (n_seen < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (n_seen < target) check_eq("timeout", n_seen, target);
    endtask

    task automatic wait_phase(input int want);
        int budget;
        budget = P + 10;
        do begin
            @(posedge clk);
            #1;
            budget--;
        end while ((cyc % P) != want && budget > 0);
        if ((cyc % P) != want) check_eq("phase_timeout", cyc % P, want);
    endtask

    task automatic pulse_sync0();
        voice_sync[0] = 1'b1;
        @(posedge clk);
        #1;
        voice_sync[0] = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle bank: silent output on the regular tick grid.
        exp_q.push_back(0);
        exp_q.push_back(0);
        wait_samples(2);

        // Voice0 square, quarter-cycle steps; syncs while idle and during its visit.
        set_voice(0, 2'd1, 24'(1 << 22), '0, 4'd0);
        exp_q.push_back(32767);
        exp_q.push_back(32767);
        exp_q.push_back(-32767);
        wait_samples(3);
        @(posedge clk);
        #1;
        pulse_sync0();
        exp_q.push_back(32767);
        exp_q.push_back(32767);
        wait_samples(2);
        exp_q.push_back(32767);
        exp_q.push_back(32767);
        exp_q.push_back(-32767);
        exp_q.push_back(-32767);
        wait_phase(1);
        pulse_sync0();
        wait_samples(4);

        // Attenuated square at half-cycle steps.
        set_voice(0, 2'd1, 24'(1 << 23), '0, 4'd3);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(4095);
            exp_q.push_back(-4096);
        end
        wait_samples(4);

        // Saturation in both directions.
        for (int v = 0; v < N; v++) set_voice(v, 2'd1, '0, '0, 4'd0);
        exp_q.push_back(32767);
        exp_q.push_back(32767);
        wait_samples(2);
        for (int v = 0; v < N; v++) set_voice(v, 2'd2, '0, '0, 4'd0);
        exp_q.push_back(-32768);
        exp_q.push_back(-32768);
        wait_samples(2);

        // Mode 3 from zero phase.
        all_off();
        exp_q.push_back(0);
        wait_samples(1);
        set_voice(0, 2'd3, 24'(1 << 20), '0, 4'd0);
`ifdef OSC_BANK_SAW_EN
        exp_q.push_back(-32768);
        exp_q.push_back(-28672);
        exp_q.push_back(-24576);
`else
        exp_q.push_back(0);
        exp_q.push_back(0);
        exp_q.push_back(0);
`endif
        wait_samples(3);

        // Reset one cycle after a tick aborts the frame.
        all_off();
        set_voice(0, 2'd1, '0, '0, 4'd0);
        wait_phase(1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.push_back(32767);
        wait_samples(1);

        check_eq("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
